// File: rtl/profile_window_pkg.sv
// profile_window_pkg: command codes, controller states and counter indices for the profiling CI
package profile_window_pkg;
  localparam logic [2:0] CMD_READ   = 3'd0;
  localparam logic [2:0] CMD_CONFIG = 3'd1;
  localparam logic [2:0] CMD_ARM    = 3'd2;
  localparam logic [2:0] CMD_WAIT   = 3'd3;
  localparam logic [2:0] CMD_SNAP   = 3'd4;
  localparam logic [2:0] CMD_STOP   = 3'd5;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
  localparam int CNT_CYCLES = 0;
  localparam int CNT_STALL  = 1;
  localparam int CNT_IDLE   = 2;
  localparam int CNT_ACTIVE = 3;
endpackage

// File: rtl/profile_counter_bank.sv
// profile_counter_bank: four wrapping event counters with per-counter clear and snapshot registers
module profile_counter_bank
  import profile_window_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            inc_i,
  input  logic [3:0]            clr_i,
  input  logic                  snap_live_i,
  input  logic                  snap_next_i,
  input  logic                  snap_clr_i,
  output logic [3:0][WIDTH-1:0] cnt_o,
  output logic [3:0][WIDTH-1:0] snap_o
);
  logic [3:0][WIDTH-1:0] cnt_q, cnt_d, snap_q, snap_d;
  // clear beats increment; snapshot takes either the post-edge values (window expiry) or the current ones
  always_comb begin
    for (int i = 0; i < 4; i++) cnt_d[i] = clr_i[i] ? '0 : cnt_q[i] + WIDTH'(inc_i[i]);
    snap_d = snap_clr_i ? '0 : snap_next_i ? cnt_d : snap_live_i ? cnt_q : snap_q;
  end
  // counter and snapshot registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end
  assign cnt_o  = cnt_q;
  assign snap_o = snap_q;
endmodule

// File: rtl/profile_window_ci.sv
// profile_window_ci: custom instruction that arms a timed profiling window and returns counter snapshots
module profile_window_ci
  import profile_window_pkg::*;
#(
  parameter logic [7:0] CUSTOM_ID = 8'd9,
  parameter int         WIDTH     = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [7:0]       ci_n_i,
  input  logic [31:0]      value_a_i,
  input  logic [WIDTH-1:0] value_b_i,
  input  logic             stall_i,
  input  logic             bus_idle_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             window_active_o
);
  state_e                state_q, state_d;
  logic [WIDTH-1:0]      timer_q, timer_d;
  logic [3:0]            mask_q, mask_d;
  logic                  pend_q, pend_d;
  logic [3:0][WIDTH-1:0] cnt, snap;
  logic [3:0]            ev, inc, clr;
  logic [2:0]            cmd;
  logic                  sel, run, expire, arm, cfg, stop, snap_cmd, wait_run, pend_done, unused_a;
  assign cmd       = value_a_i[2:0];
  assign unused_a  = ^value_a_i[31:3];
  assign sel       = start_i && ci_n_i == CUSTOM_ID;
  assign run       = state_q == RUN;
  assign expire    = run && timer_q == WIDTH'(1);
  assign arm       = sel && cmd == CMD_ARM;
  assign cfg       = sel && cmd == CMD_CONFIG;
  assign stop      = sel && cmd == CMD_STOP && run;
  assign snap_cmd  = sel && cmd == CMD_SNAP;
  assign wait_run  = sel && cmd == CMD_WAIT && run;
  assign pend_done = pend_q && state_q == HOLD;
  assign ev[CNT_CYCLES] = 1'b1;
  assign ev[CNT_STALL]  = stall_i;
  assign ev[CNT_IDLE]   = bus_idle_i;
  assign ev[CNT_ACTIVE] = !stall_i;
  assign inc = run ? mask_q & ev : 4'h0;
  assign clr = arm ? 4'hF : cfg ? value_b_i[7:4] : 4'h0;
  profile_counter_bank #(.WIDTH(WIDTH)) u_bank (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .inc_i       (inc),
    .clr_i       (clr),
    .snap_live_i (snap_cmd || stop),
    .snap_next_i (expire),
    .snap_clr_i  (arm),
    .cnt_o       (cnt),
    .snap_o      (snap)
  );
  // next state: ARM restarts from anywhere, expiry or STOP closes the window; a blocked WAIT retires on the first HOLD cycle
  always_comb begin
    state_d = arm ? RUN : (expire || stop) ? HOLD : state_q;
    timer_d = arm ? value_b_i : (run && timer_q != '0) ? timer_q - WIDTH'(1) : timer_q;
    mask_d  = cfg ? value_b_i[3:0] : mask_q;
    pend_d  = wait_run ? 1'b1 : pend_done ? 1'b0 : pend_q;
  end
  // controller registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      mask_q  <= 4'b1111;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
    end
  end
  // completion and result mux; result stays 0 whenever done is low
  always_comb begin
    done_o   = pend_done || (sel && !wait_run);
    result_o = pend_done ? snap[CNT_CYCLES] :
               !sel ? '0 :
               cmd == CMD_READ ? snap[value_b_i[1:0]] :
               (cmd == CMD_WAIT && !run) ? snap[CNT_CYCLES] :
               cmd == CMD_SNAP ? cnt[CNT_CYCLES] : '0;
  end
  assign window_active_o = run;
endmodule
